// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package seg_pkg;

    // Active-low pattern with every segment (and DP) off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Digit-entry field positions: {dp, blank, hex[3:0]}.
    localparam int DP_BIT    = 5;
    localparam int BLANK_BIT = 4;

    // Active-low segment bit order on seg_n: {A,B,C,D,E,F,G,DP}.
    localparam int SEG_A_BIT  = 7;
    localparam int SEG_B_BIT  = 6;
    localparam int SEG_C_BIT  = 5;
    localparam int SEG_D_BIT  = 4;
    localparam int SEG_E_BIT  = 3;
    localparam int SEG_F_BIT  = 2;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Entry value that displays nothing.
    localparam logic [5:0] ENTRY_BLANK = 6'b010000;

    // Phase within one digit slot.
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_e;

endpackage

// File: rtl/seg_scan_ctrl_font.sv
// Combinational hex font: 6-bit digit entry to active-low segment pattern.
module seg_font
    import seg_pkg::*;
(
    input  logic [5:0] entry_i,
    output logic [7:0] seg_n_o
);

    logic [7:0] pat;

    // Hex glyph lookup, then DP, then blank overrides everything.
    always_comb begin
        pat = SEG_BLANK;
        case (entry_i[3:0])
            4'h0: pat = 8'h03;
            4'h1: pat = 8'h9F;
            4'h2: pat = 8'h25;
            4'h3: pat = 8'h0D;
            4'h4: pat = 8'h99;
            4'h5: pat = 8'h49;
            4'h6: pat = 8'h41;
            4'h7: pat = 8'h1F;
            4'h8: pat = 8'h01;
            4'h9: pat = 8'h09;
            4'hA: pat = 8'h11;
            4'hB: pat = 8'hC1;
            4'hC: pat = 8'h63;
            4'hD: pat = 8'h85;
            4'hE: pat = 8'h61;
            4'hF: pat = 8'h71;
            default: pat = SEG_BLANK;
        endcase
        if (entry_i[DP_BIT])
            pat[SEG_DP_BIT] = 1'b0;
        seg_n_o = entry_i[BLANK_BIT] ? SEG_BLANK : pat;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// buffer copy, per-slot blank gap and 8-level PWM brightness.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 25000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [1:0] wr_addr,
    input  logic [5:0] wr_data,
    input  logic [2:0] bright,
    output logic [3:0] an_n,
    output logic [7:0] seg_n,
    output logic       frame_tick
);

    localparam logic [15:0] CNT_LAST  = 16'(DIGIT_CYCLES - 1);
    localparam logic [15:0] BLANK_END = 16'(BLANK_CYCLES);
    localparam phase_e      PH_RESET  = (BLANK_CYCLES == 0) ? PH_ON : PH_BLANK;

    logic [1:0]  digit_q, digit_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  pwm_q;
    logic [2:0]  bright_q;
    phase_e      phase_q, phase_d;
    logic [5:0]  shadow_q [4];
    logic [5:0]  active_q [4];
    logic [3:0]  an_n_q;
    logic [7:0]  seg_n_q;
    logic        tick_q;

    logic        copy_cycle;
    logic        wr_fire;
    logic [5:0]  cur_entry;
    logic [7:0]  cur_seg_n;
    logic        lit;

    assign copy_cycle = (digit_q == 2'd0) && (cnt_q == 16'd0);
    assign wr_ready   = !rst && !copy_cycle;
    assign wr_fire    = wr_valid && wr_ready;
    assign cur_entry  = active_q[digit_q];

    seg_font u_font (
        .entry_i (cur_entry),
        .seg_n_o (cur_seg_n)
    );

    // Slot counter and digit index advance.
    always_comb begin
        cnt_d   = cnt_q + 16'd1;
        digit_d = digit_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d   = 16'd0;
            digit_d = digit_q + 2'd1;
        end
    end

    // Phase next-state: blank gap at the start of each slot, then on.
    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_BLANK: if (cnt_d >= BLANK_END) phase_d = PH_ON;
            PH_ON:    if (cnt_d <  BLANK_END) phase_d = PH_BLANK;
            default:  phase_d = PH_RESET;
        endcase
    end

    // Scan state registers; brightness is latched only at slot start.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= 16'd0;
            digit_q  <= 2'd0;
            pwm_q    <= 3'd0;
            bright_q <= 3'd0;
            phase_q  <= PH_RESET;
        end else begin
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            pwm_q   <= pwm_q + 3'd1;
            phase_q <= phase_d;
            if (cnt_q == 16'd0)
                bright_q <= bright;
        end
    end

    // Display buffers: writes land in shadow, shadow moves to active once per frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                shadow_q[i] <= ENTRY_BLANK;
                active_q[i] <= ENTRY_BLANK;
            end
        end else begin
            if (wr_fire)
                shadow_q[wr_addr] <= wr_data;
            if (copy_cycle)
                for (int i = 0; i < 4; i++)
                    active_q[i] <= shadow_q[i];
        end
    end

    // A blanked digit also keeps its anode off so an empty display stays fully dark.
    assign lit = (phase_q == PH_ON) && (pwm_q <= bright_q) && !cur_entry[BLANK_BIT];

    // Registered pin drivers; anode and segments always change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_n_q  <= 4'hF;
            seg_n_q <= SEG_BLANK;
            tick_q  <= 1'b0;
        end else begin
            an_n_q  <= lit ? ~(4'b0001 << digit_q) : 4'hF;
            seg_n_q <= lit ? cur_seg_n : SEG_BLANK;
            tick_q  <= copy_cycle;
        end
    end

    assign an_n       = an_n_q;
    assign seg_n      = seg_n_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with a small per-cycle expectation model.
module tb_seg_scan_ctrl;

    localparam int DC = 16;
    localparam int BC = 4;
    localparam int FR = 4 * DC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_valid = 1'b0;
    logic [1:0] wr_addr = 2'd0;
    logic [5:0] wr_data = 6'd0;
    logic [2:0] bright = 3'd0;
    logic       wr_ready;
    logic [3:0] an_n;
    logic [7:0] seg_n;
    logic       frame_tick;

    seg_scan_ctrl #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .bright     (bright),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int k        = 0;             // cycles since reset release (0 = copy cycle)

    logic [7:0] m_sh  [4];        // expected glyphs written, per digit
    logic [7:0] m_act [4];        // expected glyphs on display, per digit
    logic [2:0] m_bq;             // expected latched brightness
    logic [7:0] wr_seg;           // hand-computed glyph of the write in flight

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s k=%0d: got %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]  = 8'hFF;
            m_act[i] = 8'hFF;
        end
        m_bq = 3'd0;
    endtask

    // One clock: predict outputs of the current cycle, update the model for
    // the closing edge, then compare on the following falling edge.
    task automatic step();
        int         d;
        int         c;
        logic       lit;
        logic [3:0] ean;
        logic [7:0] eseg;
        logic       eft;
        d    = (k / DC) % 4;
        c    = k % DC;
        lit  = (c >= BC) && ((k % 8) <= int'(m_bq)) && (m_act[d] != 8'hFF);
        ean  = lit ? ~(4'b0001 << d) : 4'hF;
        eseg = lit ? m_act[d] : 8'hFF;
        eft  = (k % FR == 0);
        if (k % FR == 0) begin
            for (int i = 0; i < 4; i++) m_act[i] = m_sh[i];
        end else if (wr_valid) begin
            m_sh[wr_addr] = wr_seg;
        end
        if (c == 0) m_bq = bright;
        @(negedge clk);
        k++;
        chk("an_n",       {4'h0, an_n},       {4'h0, ean});
        chk("seg_n",      seg_n,              eseg);
        chk("frame_tick", {7'h0, frame_tick}, {7'h0, eft});
        chk("wr_ready",   {7'h0, wr_ready},   {7'h0, (k % FR != 0)});
    endtask

    task automatic wr(input logic [1:0] a, input logic [5:0] data, input logic [7:0] s);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = data;
        wr_seg   = s;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) begin
            @(negedge clk);
            chk("rst_an_n",       {4'h0, an_n},       8'h0F);
            chk("rst_seg_n",      seg_n,              8'hFF);
            chk("rst_frame_tick", {7'h0, frame_tick}, 8'h00);
            chk("rst_wr_ready",   {7'h0, wr_ready},   8'h00);
        end
        model_reset();
        k   = 0;
        rst = 1'b0;
    endtask

    initial begin
        wr_seg = 8'hFF;
        model_reset();

        // Power-on reset, then three dark frames with no writes.
        do_reset(3);
        repeat (3 * FR) step();

        // Load 1, 2, A., F at full brightness; visible from the frame at k=256.
        bright = 3'd7;
        step();
        wr(2'd0, 6'h01, 8'h9F);
        wr(2'd1, 6'h02, 8'h25);
        wr(2'd2, 6'h2A, 8'h10);
        wr(2'd3, 6'h0F, 8'h71);
        while (k < 5 * FR) step();

        // Minimum brightness with digit 0 = 8, then raise to 3 mid-slot.
        step();
        bright = 3'd0;
        wr(2'd0, 6'h08, 8'h01);
        while (k < 405) step();
        bright = 3'd3;
        while (k < 440) step();
        bright = 3'd7;
        while (k < 7 * FR) step();

        // Write held across the copy cycle: refused there, taken one cycle later.
        wr_valid = 1'b1;
        wr_addr  = 2'd1;
        wr_data  = 6'h05;
        wr_seg   = 8'h49;
        chk("copy_wr_ready", {7'h0, wr_ready}, 8'h00);
        step();
        chk("post_copy_wr_ready", {7'h0, wr_ready}, 8'h01);
        step();
        wr_valid = 1'b0;
        while (k < 8 * FR + 1) step();

        // Two writes to digit 2 in one frame: the later one (7) must win.
        wr(2'd2, 6'h03, 8'h0D);
        wr(2'd2, 6'h07, 8'h1F);
        while (k < 10 * FR + 20) step();

        // Mid-frame reset with a pending write: everything returns to blank.
        wr(2'd3, 6'h05, 8'h49);
        do_reset(1);
        repeat (2 * FR) step();

        // Scan restarts at digit 0 after reset.
        step();
        wr(2'd0, 6'h01, 8'h9F);
        while (k < 4 * FR) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
